// File: rtl/frame_motion_updater.sv
// ============================================================================
// Module  : frame_motion_updater
// Brief   : Steps N_OBJ bouncing objects once per frame tick, one object/cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_motion_updater #(
    parameter int N_OBJ = 4,
    parameter int IDX_W = 2,
    parameter int STEP  = 2,
    parameter int X_MAX = 623,
    parameter int Y_MAX = 463
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    output logic             tick_clr,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [9:0]       load_x,
    input  logic [8:0]       load_y,
    input  logic [1:0]       load_dir,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [9:0]       rd_x,
    output logic [8:0]       rd_y,
    output logic [1:0]       rd_dir,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;

    localparam int               c_LAST_I = N_OBJ - 1;
    localparam logic [IDX_W-1:0] c_LAST   = c_LAST_I[IDX_W-1:0];
    localparam logic [IDX_W:0]   c_NOBJ   = N_OBJ[IDX_W:0];
    localparam logic [10:0]      c_STEP   = STEP[10:0];
    localparam logic [10:0]      c_XMAX   = X_MAX[10:0];
    localparam logic [10:0]      c_YMAX   = Y_MAX[10:0];

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             tick_clr_q;
    logic [9:0]       x_q   [N_OBJ];
    logic [9:0]       x_d   [N_OBJ];
    logic [8:0]       y_q   [N_OBJ];
    logic [8:0]       y_d   [N_OBJ];
    logic [1:0]       dir_q [N_OBJ];
    logic [1:0]       dir_d [N_OBJ];

    logic [9:0]  w_sel_x, w_nx;
    logic [8:0]  w_sel_y, w_ny;
    logic [1:0]  w_sel_dir, w_ndir;
    logic [10:0] w_sx, w_sy;
    logic        w_last;
    logic        w_load_ok;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (tick) state_d = S_UPDATE;
            S_UPDATE: if (w_last) state_d = S_ACK;
            S_ACK:    if (!tick) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == S_UPDATE) || (state_q == S_ACK);
    end

    // ---------------- Datapath: selected object's next position ----------------
    always_comb begin
        w_last    = (idx_q == c_LAST);
        w_load_ok = (state_q == S_IDLE) && load_en && ({1'b0, load_idx} < c_NOBJ);
        w_sel_x   = x_q[idx_q];
        w_sel_y   = y_q[idx_q];
        w_sel_dir = dir_q[idx_q];
        w_sx      = {1'b0, w_sel_x} + c_STEP;
        w_sy      = {2'b0, w_sel_y} + c_STEP;
        w_ndir    = w_sel_dir;
        // Sums are 11 bits wide so the comparison against the limit cannot wrap
        if (!w_sel_dir[1]) begin
            if (w_sx > c_XMAX) begin
                w_nx      = c_XMAX[9:0];
                w_ndir[1] = 1'b1;
            end else begin
                w_nx = w_sx[9:0];
            end
        end else if ({1'b0, w_sel_x} < c_STEP) begin
            w_nx      = 10'd0;
            w_ndir[1] = 1'b0;
        end else begin
            w_nx = w_sel_x - c_STEP[9:0];
        end
        if (!w_sel_dir[0]) begin
            if (w_sy > c_YMAX) begin
                w_ny      = c_YMAX[8:0];
                w_ndir[0] = 1'b1;
            end else begin
                w_ny = w_sy[8:0];
            end
        end else if ({2'b0, w_sel_y} < c_STEP) begin
            w_ny      = 9'd0;
            w_ndir[0] = 1'b0;
        end else begin
            w_ny = w_sel_y - c_STEP[8:0];
        end
    end

    always_comb begin
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        if (state_q == S_IDLE) begin
            idx_d = '0;
        end else if (state_q == S_UPDATE) begin
            idx_d = w_last ? '0 : idx_q + 1'b1;
            if (w_last) frame_cnt_d = frame_cnt_q + 16'd1;
        end
        for (int i = 0; i < N_OBJ; i++) begin
            x_d[i]   = x_q[i];
            y_d[i]   = y_q[i];
            dir_d[i] = dir_q[i];
            if (w_load_ok && (load_idx == i[IDX_W-1:0])) begin
                x_d[i]   = load_x;
                y_d[i]   = load_y;
                dir_d[i] = load_dir;
            end
            if ((state_q == S_UPDATE) && (idx_q == i[IDX_W-1:0])) begin
                x_d[i]   = w_nx;
                y_d[i]   = w_ny;
                dir_d[i] = w_ndir;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            frame_cnt_q <= '0;
            tick_clr_q  <= 1'b0;
            for (int i = 0; i < N_OBJ; i++) begin
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                dir_q[i] <= '0;
            end
        end else begin
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            tick_clr_q  <= (state_d == S_ACK);
            for (int i = 0; i < N_OBJ; i++) begin
                x_q[i]   <= x_d[i];
                y_q[i]   <= y_d[i];
                dir_q[i] <= dir_d[i];
            end
        end
    end

    // ---------------- Read port ----------------
    always_comb begin
        rd_x   = '0;
        rd_y   = '0;
        rd_dir = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (rd_idx == i[IDX_W-1:0]) begin
                rd_x   = x_q[i];
                rd_y   = y_q[i];
                rd_dir = dir_q[i];
            end
        end
    end

    assign tick_clr  = tick_clr_q;
    assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire
